trace_msg_arbiter: RTL and testbench
====================================

Name: trace_msg_arbiter

Overview:
- Shares one message/trace output channel between N_REQ requesters (testbench monitors, $display-style loggers, debug taps).
- Round-robin arbitration at message granularity: once granted, a source keeps the channel until its last beat.
- A registered output stage decouples downstream backpressure.
- Messages longer than MAX_BEATS are force-terminated and flagged.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 32, payload width per beat.
- MAX_BEATS, 16, maximum beats per message before forced termination (>=2).
- SRC_W, $clog2(N_REQ), localparam width of the source index.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-source beat valid.
- req_data  input  N_REQ x DATA_W  per-source payload.
- req_last  input  N_REQ  per-source last beat of message.
- req_ready  output  N_REQ  per-source beat accepted.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_W  output payload.
- out_last  output  1  last beat of output message.
- out_src  output  SRC_W  index of the source owning the beat.
- out_ready  input  1  downstream accepts beat.
- err_overlong  output  1  one-cycle pulse: message truncated at MAX_BEATS.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - err_overlong=0, req_ready=0.
  - Reset mid-message drops the message and any held output beat without emitting last.
- slot_free = !out_valid || out_ready.
- States:
  - IDLE: sel = first index with req_valid set, searching rr_ptr, rr_ptr+1, ... mod N_REQ. req_ready[sel] = slot_free; all other req_ready are 0.
  - LOCK: owner register holds the granted source. req_ready[owner] = slot_free; all others 0.
- Beat accept (req_valid[g] && req_ready[g]):
  - Output register loads data, last, and src=g.
  - out_valid is 1 the next cycle, giving 1-cycle latency.
  - beat_cnt increments.
- Transitions:
  - IDLE->LOCK when a non-last beat is accepted; owner<=sel.
  - IDLE stays IDLE when a single-beat message (req_last=1) is accepted.
  - LOCK->IDLE when the accepted beat has req_last=1 or beat_cnt==MAX_BEATS-1.
  - On every return to IDLE: rr_ptr <= g+1 mod N_REQ, beat_cnt <= 0.
- Overlong handling:
  - Triggered when the accepted beat has beat_cnt==MAX_BEATS-1 and req_last=0.
  - out_last is forced to 1, and err_overlong pulses in the same cycle out_valid first shows that beat.
  - The source's remaining beats re-arbitrate as a new message.
- LOCK with req_valid[owner]=0: wait indefinitely, no timeout, no grant to others.
- Output hold: out_valid && !out_ready keeps out_data, out_last and out_src stable, and req_ready stays 0.
- Throughput: out_ready held at 1 allows one beat per cycle, including back-to-back messages from different sources with no bubble.
- req_valid deasserted in IDLE before acceptance: no grant, rr_ptr unchanged.
- The arbiter ignores req_data and req_last of non-granted sources.
- N_REQ=1 is illegal; an elaboration-time check rejects it.

Decomposition:
- Shared package trace_arb_pkg:
  - arb_state_e {IDLE, LOCK}.
  - Default constants TRACE_ARB_N_REQ and TRACE_ARB_DATA_W.
  - Function next_idx(idx, n) for wrap-around.
- Sub-module rr_pick: combinational find-first-set from a rotating pointer. Inputs are req vector and ptr; outputs are sel index and any.
- Protocol assertions live in the block under `ifdef TRACE_ARB_ASSERT:
  - out_* stable under backpressure.
  - At most one req_ready bit set.

Test Plan (N_REQ=4, DATA_W=8, MAX_BEATS=4):
- Fairness: sources 0..3 all hold valid with single-beat messages, out_ready=1 → out_src sequence 0,1,2,3,0,...; one beat per cycle; first out_valid one cycle after first accept.
- Message lock: src1 sends 3 beats (0x11,0x12,0x13 last) while src2 is valid → out emits 0x11,0x12,0x13 from src1, then src2.
- Backpressure: out_ready=0 for 5 cycles mid-message → out_data frozen, req_ready all 0; the release delivers the remaining beats in order with no loss or duplication.
- Overlong: src3 sends 6 beats with no last → beat 4 has out_last=1 and err_overlong pulses once; then src0 (valid) is granted before src3's beats 5–6.
- Owner stall: src2 is locked and drops valid for 3 cycles while src0 is valid → src0 is not granted until src2's last beat.
- Reset mid-message: rst for 1 cycle during src1 beat 2 → next cycle out_valid=0 and rr_ptr=0; src0 is granted first afterwards.

Source files
------------

// File: rtl/trace_arb_pkg.sv
// Shared types, defaults and helpers for the trace message arbiter.
package trace_arb_pkg;

   localparam int unsigned TRACE_ARB_N_REQ     = 4;
   localparam int unsigned TRACE_ARB_DATA_W    = 32;
   localparam int unsigned TRACE_ARB_MAX_BEATS = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   // Wrap-around increment of a source index.
   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/trace_msg_arbiter_if.sv
// Requester-side and output-side handshake bundle for trace_msg_arbiter.
interface trace_msg_arbiter_if
   import trace_arb_pkg::*;
#(
   parameter int unsigned N_REQ  = TRACE_ARB_N_REQ,
   parameter int unsigned DATA_W = TRACE_ARB_DATA_W
);

   localparam int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]             req_valid;
   logic [N_REQ-1:0][DATA_W-1:0] req_data;
   logic [N_REQ-1:0]             req_last;
   logic [N_REQ-1:0]             req_ready;

   logic                         out_valid;
   logic [DATA_W-1:0]            out_data;
   logic                         out_last;
   logic [SRC_W-1:0]             out_src;
   logic                         out_ready;
   logic                         err_overlong;

   modport slave (
      input  req_valid, req_data, req_last, out_ready,
      output req_ready, out_valid, out_data, out_last, out_src, err_overlong
   );

   modport master (
      output req_valid, req_data, req_last, out_ready,
      input  req_ready, out_valid, out_data, out_last, out_src, err_overlong
   );

endinterface

// File: rtl/rr_pick.sv
// Find-first-set over a request vector, starting at a rotating pointer.
module rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic [SEL_W-1:0] sel_o,
   output logic             any_o
);

   // Scan from farthest to nearest so the closest set bit after ptr wins.
   always_comb begin
      logic [SEL_W-1:0] idx;
      idx   = '0;
      sel_o = '0;
      any_o = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = SEL_W'((32'(ptr_i) + (N - 1 - k)) % N);
         if (req_i[idx]) begin
            sel_o = idx;
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/trace_msg_arbiter.sv
// Round-robin, message-granular arbiter sharing one registered trace output
// channel between N_REQ requesters, with forced termination of overlong messages.
module trace_msg_arbiter
   import trace_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = TRACE_ARB_N_REQ,
   parameter int unsigned DATA_W    = TRACE_ARB_DATA_W,
   parameter int unsigned MAX_BEATS = TRACE_ARB_MAX_BEATS
) (
   input logic                clk,
   input logic                rst,
   trace_msg_arbiter_if.slave bus
);

   localparam int unsigned SRC_W = $clog2(N_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

   if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
      $error("trace_msg_arbiter: N_REQ must be within 2..16");
   end
   if (MAX_BEATS < 2) begin : g_bad_max_beats
      $error("trace_msg_arbiter: MAX_BEATS must be at least 2");
   end

   arb_state_e        state_q, state_d;
   logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]  owner_q, owner_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic [SRC_W-1:0]  out_src_q, out_src_d;
   logic              err_q, err_d;

   logic [SRC_W-1:0]  pick_sel;
   logic              pick_any;
   logic              slot_free;
   logic [SRC_W-1:0]  grant_idx;
   logic              grant_en;
   logic [N_REQ-1:0]  ready;
   logic              accept;
   logic              beat_last;
   logic              overlong;
   logic              msg_end;

   rr_pick #(
      .N     (N_REQ),
      .SEL_W (SRC_W)
   ) u_rr_pick (
      .req_i (bus.req_valid),
      .ptr_i (rr_ptr_q),
      .sel_o (pick_sel),
      .any_o (pick_any)
   );

   // Grant selection and beat-accept decode.
   always_comb begin
      slot_free = !out_valid_q || bus.out_ready;
      grant_idx = (state_q == LOCK) ? owner_q : pick_sel;
      grant_en  = (state_q == LOCK) || pick_any;
      ready     = '0;
      if (!rst && grant_en) begin
         ready[grant_idx] = slot_free;
      end
      accept    = bus.req_valid[grant_idx] && ready[grant_idx];
      beat_last = bus.req_last[grant_idx];
      overlong  = accept && !beat_last && (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
      msg_end   = accept && (beat_last || overlong);
   end

   // Next state, pointer, counter and output stage.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      beat_cnt_d  = beat_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_src_d   = out_src_q;
      err_d       = 1'b0;

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.req_data[grant_idx];
         out_last_d  = beat_last || overlong;
         out_src_d   = grant_idx;
         err_d       = overlong;
         if (msg_end) begin
            state_d    = IDLE;
            rr_ptr_d   = SRC_W'(next_idx(32'(grant_idx), N_REQ));
            beat_cnt_d = '0;
         end else begin
            state_d    = LOCK;
            owner_d    = grant_idx;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_src_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         beat_cnt_q  <= beat_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_src_q   <= out_src_d;
         err_q       <= err_d;
      end
   end

   assign bus.req_ready    = ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_data     = out_data_q;
   assign bus.out_last     = out_last_q;
   assign bus.out_src      = out_src_q;
   assign bus.err_overlong = err_q;

`ifdef TRACE_ARB_ASSERT
   a_out_hold: assert property (@(posedge clk) disable iff (rst)
      (out_valid_q && !bus.out_ready) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_last_q) && $stable(out_src_q)));

   a_ready_onehot: assert property (@(posedge clk) $onehot0(ready));
`endif

endmodule

// File: tb/tb_trace_msg_arbiter.sv
// Self-checking bench for trace_msg_arbiter: vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_trace_msg_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst;

   trace_msg_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

   trace_msg_arbiter #(
      .N_REQ     (N),
      .DATA_W    (DW),
      .MAX_BEATS (MB)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: owner (-1 = none), pointer, beats taken, output slot.
   int         m_owner, m_ptr, m_cnt, m_os;
   bit         m_ov, m_ol, m_err;
   logic [7:0] m_od;

   typedef struct {
      logic [3:0] valid;
      logic [3:0] last;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_ov;
      logic [1:0] exp_src;
      logic [7:0] exp_data;
      logic       exp_last;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_grant();
      if (m_owner >= 0) return m_owner;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (bus.req_valid[2'(idx)]) return idx;
      end
      return -1;
   endfunction

   task automatic model_update();
      int g;
      bit acc, lst, ovl;
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_cnt = 0;
         m_ov = 0; m_od = '0; m_ol = 0; m_os = 0; m_err = 0;
         return;
      end
      g     = m_grant();
      acc   = (g >= 0) && bus.req_valid[2'(g)] && (!m_ov || bus.out_ready);
      m_err = 0;
      if (acc) begin
         lst   = bus.req_last[2'(g)];
         ovl   = !lst && (m_cnt == MB - 1);
         m_ov  = 1;
         m_od  = bus.req_data[2'(g)];
         m_ol  = lst || ovl;
         m_os  = g;
         m_err = ovl;
         if (lst || ovl) begin
            m_owner = -1;
            m_ptr   = (g + 1) % N;
            m_cnt   = 0;
         end else begin
            m_owner = g;
            m_cnt++;
         end
      end else if (bus.out_ready) begin
         m_ov = 0;
      end
   endtask

   // One clock: check combinational ready, clock, check registered outputs.
   task automatic step();
      logic [3:0] er;
      int g;
      #1;
      g  = m_grant();
      er = '0;
      if (!rst && g >= 0 && (!m_ov || bus.out_ready)) er = 4'(1 << g);
      chk("model_req_ready", 32'(bus.req_ready), 32'(er));
      @(posedge clk);
      model_update();
      #1;
      chk("model_out_valid", 32'(bus.out_valid), 32'(m_ov));
      if (m_ov) begin
         chk("model_out_data", 32'(bus.out_data), 32'(m_od));
         chk("model_out_last", 32'(bus.out_last), 32'(m_ol));
         chk("model_out_src", 32'(bus.out_src), 32'(m_os));
      end
      chk("model_err_overlong", 32'(bus.err_overlong), 32'(m_err));
   endtask

   task automatic set_src(input int s, input bit v, input logic [7:0] d, input bit l);
      bus.req_valid[2'(s)] = v;
      bus.req_data[2'(s)]  = d;
      bus.req_last[2'(s)]  = l;
   endtask

   task automatic exp_out(input string name, input int s, input logic [7:0] d, input bit l, input bit e);
      chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_src"}, 32'(bus.out_src), 32'(s));
      chk({name, "_data"}, 32'(bus.out_data), 32'(d));
      chk({name, "_last"}, 32'(bus.out_last), 32'(l));
      chk({name, "_err"}, 32'(bus.err_overlong), 32'(e));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = '1;
      bus.req_last  = '1;
      bus.out_ready = 1'b1;
      step();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      chk("rst_out_src", 32'(bus.out_src), 32'd0);
      chk("rst_err", 32'(bus.err_overlong), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      bus.req_valid = '0;
      bus.req_last  = '0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.out_ready = 1'b1;
      model_update();

      // Fairness, bubble-free throughput and backpressure hold.
      tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0, 1'b1};
      tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1, 1'b1};
      tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2, 1'b1};
      tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3, 1'b1};
      tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0, 1'b1};
      tbl[5]  = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};
      tbl[6]  = '{4'h4, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2, 1'b1};
      tbl[7]  = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 8'hA2, 1'b1};
      tbl[8]  = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd2, 8'hA2, 1'b1};
      tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3, 1'b1};
      tbl[10] = '{4'h3, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0, 1'b1};
      tbl[11] = '{4'h3, 4'h3, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1, 1'b1};
      tbl[12] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};

      do_reset();
      for (int s = 0; s < N; s++) bus.req_data[2'(s)] = 8'(8'hA0 + s);
      for (int i = 0; i < 13; i++) begin
         bus.req_valid = tbl[i].valid;
         bus.req_last  = tbl[i].last;
         bus.out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("tbl%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].exp_rdy));
         step();
         chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_ov));
         if (tbl[i].exp_ov) begin
            chk($sformatf("tbl%0d_src", i), 32'(bus.out_src), 32'(tbl[i].exp_src));
            chk($sformatf("tbl%0d_data", i), 32'(bus.out_data), 32'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_last", i), 32'(bus.out_last), 32'(tbl[i].exp_last));
         end
      end

      // Message lock: src1 keeps the channel while src2 waits.
      do_reset();
      set_src(1, 1, 8'h11, 0);
      set_src(2, 1, 8'h21, 1);
      step(); exp_out("lock_b1", 1, 8'h11, 0, 0);
      set_src(1, 1, 8'h12, 0);
      step(); exp_out("lock_b2", 1, 8'h12, 0, 0);
      set_src(1, 1, 8'h13, 1);
      step(); exp_out("lock_b3", 1, 8'h13, 1, 0);
      set_src(1, 0, 8'h00, 0);
      step(); exp_out("lock_src2", 2, 8'h21, 1, 0);

      // Backpressure mid-message: output frozen, nothing accepted.
      do_reset();
      set_src(0, 1, 8'h31, 0);
      step(); exp_out("bp_b1", 0, 8'h31, 0, 0);
      set_src(0, 1, 8'h32, 0);
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_ready_zero", 32'(bus.req_ready), 32'd0);
         step();
         exp_out("bp_hold", 0, 8'h31, 0, 0);
      end
      bus.out_ready = 1'b1;
      step(); exp_out("bp_b2", 0, 8'h32, 0, 0);
      set_src(0, 1, 8'h33, 1);
      step(); exp_out("bp_b3", 0, 8'h33, 1, 0);
      set_src(0, 0, 8'h00, 0);
      step(); chk("bp_drain", 32'(bus.out_valid), 32'd0);

      // Overlong: src3 cut at beat 4, src0 then wins before src3 resumes.
      do_reset();
      set_src(3, 1, 8'h41, 0);
      step(); exp_out("ovl_b1", 3, 8'h41, 0, 0);
      set_src(3, 1, 8'h42, 0);
      step(); exp_out("ovl_b2", 3, 8'h42, 0, 0);
      set_src(3, 1, 8'h43, 0);
      step(); exp_out("ovl_b3", 3, 8'h43, 0, 0);
      set_src(3, 1, 8'h44, 0);
      set_src(0, 1, 8'h01, 1);
      step(); exp_out("ovl_b4_cut", 3, 8'h44, 1, 1);
      set_src(3, 1, 8'h45, 0);
      step(); exp_out("ovl_src0", 0, 8'h01, 1, 0);
      set_src(0, 0, 8'h00, 0);
      step(); exp_out("ovl_b5", 3, 8'h45, 0, 0);
      set_src(3, 1, 8'h46, 0);
      step(); exp_out("ovl_b6", 3, 8'h46, 0, 0);
      set_src(3, 0, 8'h00, 0);
      step();

      // Owner stall: src2 locked and idle, src0 must keep waiting.
      do_reset();
      set_src(2, 1, 8'h51, 0);
      step(); exp_out("stall_b1", 2, 8'h51, 0, 0);
      set_src(2, 0, 8'h00, 0);
      set_src(0, 1, 8'h07, 1);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_no_grant", 32'(bus.req_ready), 32'h4);
         step();
         chk("stall_out_idle", 32'(bus.out_valid), 32'd0);
      end
      set_src(2, 1, 8'h52, 1);
      step(); exp_out("stall_b2", 2, 8'h52, 1, 0);
      set_src(2, 0, 8'h00, 0);
      step(); exp_out("stall_src0", 0, 8'h07, 1, 0);

      // Reset mid-message drops the held beat and restarts at src0.
      do_reset();
      set_src(1, 1, 8'h61, 0);
      step(); exp_out("rmid_b1", 1, 8'h61, 0, 0);
      set_src(1, 1, 8'h62, 0);
      set_src(0, 1, 8'h08, 1);
      rst = 1'b1;
      step();
      chk("rmid_out_valid", 32'(bus.out_valid), 32'd0);
      rst = 1'b0;
      set_src(1, 1, 8'h63, 1);
      #1;
      chk("rmid_ready", 32'(bus.req_ready), 32'h1);
      step(); exp_out("rmid_src0", 0, 8'h08, 1, 0);

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int s = 0; s < N; s++) begin
            set_src(s, $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 2) == 0);
         end
         bus.out_ready = $urandom_range(0, 3) != 0;
         rst           = $urandom_range(0, 299) == 0;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
